rbuf_dp_ctrl: RTL

- Ring-buffer (FIFO) controller that sequences one dual-port block memory: write port A, read port B, 2-cycle registered read latency, behavioural read-first on same-address collisions.
- The memory itself stays external, as the existing dual-port output-registered memory block instantiated alongside it; this block drives its ports.
- Presents a push interface on the write side and a valid/ready stream on the read side.
- Hides the read latency with a prefetch pipeline and a small output FIFO.

---
 rtl/rbuf_pkg.sv | 21 ++
 rtl/rbuf_dp_ctrl_if.sv | 46 ++++
 rtl/rbuf_ofifo.sv | 91 +++++++++
 rtl/rbuf_dp_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/rbuf_pkg.sv
// -----------------------------------------------------------------------------
// rbuf_pkg
//   Shared constants for the ring-buffer dual-port memory controller.
//   OFIFO_DEPTH : entries in the output register FIFO that hides read latency.
//   MEM_RD_LAT  : read latency of the external memory, which sets the length
//                 of the in-flight tag pipe.
//   cnt_w()     : width of an occupancy counter for a given address width.
//                 It holds 0..2**addr_w inclusive, so it needs one extra bit.
// -----------------------------------------------------------------------------
package rbuf_pkg;

    localparam int OFIFO_DEPTH = 4;
    localparam int OFIFO_PTR_W = $clog2(OFIFO_DEPTH);
    localparam int OFIFO_OCC_W = OFIFO_PTR_W + 1;
    localparam int MEM_RD_LAT  = 2;

    function automatic int cnt_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/rbuf_dp_ctrl_if.sv
// -----------------------------------------------------------------------------
// rbuf_dp_ctrl_if
//   Bundles the push side, the read stream and the memory port pins of the
//   ring-buffer controller.
//   modport slave  : the controller. It takes pushes and rd_ready and drives
//                    the status flags, the read stream and the memory ports.
//   modport master : the environment. It pushes words, consumes the stream
//                    and returns memory read data.
// -----------------------------------------------------------------------------
interface rbuf_dp_ctrl_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
);
    // push side
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              almost_full;
    logic              overflow;
    logic [ADDR_W:0]   count;
    // read stream
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    // memory ports (A = write, B = read)
    logic [ADDR_W-1:0] mem_addra;
    logic              mem_wea;
    logic [DATA_W-1:0] mem_dia;
    logic [ADDR_W-1:0] mem_addrb;
    logic [DATA_W-1:0] mem_resb;

    modport slave (
        input  wr_en, wr_data, rd_ready, mem_resb,
        output full, almost_full, overflow, count,
               rd_valid, rd_data,
               mem_addra, mem_wea, mem_dia, mem_addrb
    );

    modport master (
        output wr_en, wr_data, rd_ready, mem_resb,
        input  full, almost_full, overflow, count,
               rd_valid, rd_data,
               mem_addra, mem_wea, mem_dia, mem_addrb
    );

endinterface

// File: rtl/rbuf_ofifo.sv
// -----------------------------------------------------------------------------
// rbuf_ofifo
//   Small register FIFO (OFIFO_DEPTH entries) that sits after the memory read
//   pipe. Its head is the controller's output word.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     flush       : synchronous clear of pointers and occupancy
//     push        : capture push_data (never asserted while full: the fetch
//                   scheduler reserves a slot before each memory read)
//     push_data   : word to capture
//     pop         : consumer ready; only acts while valid
//     valid       : FIFO non-empty
//     head        : head word; when empty it shows the word popped last
//     occ         : current number of entries
// -----------------------------------------------------------------------------
module rbuf_ofifo
    import rbuf_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [DATA_W-1:0]      push_data,
    input  logic                   pop,
    output logic                   valid,
    output logic [DATA_W-1:0]      head,
    output logic [OFIFO_OCC_W-1:0] occ
);

    logic [OFIFO_PTR_W-1:0] wr_ptr_reg;
    logic [OFIFO_PTR_W-1:0] rd_ptr_reg;
    logic [OFIFO_PTR_W-1:0] last_ptr;
    logic [OFIFO_OCC_W-1:0] occ_reg;
    logic [DATA_W-1:0]      slot_data [OFIFO_DEPTH];
    logic                   do_push;
    logic                   do_pop;

    assign do_push = push & ~flush;
    assign do_pop  = pop & (occ_reg != '0) & ~flush;

    genvar gi;
    generate
        for (gi = 0; gi < OFIFO_DEPTH; gi++) begin : g_slot
            logic [DATA_W-1:0] q_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_reg <= '0;
                end else if (do_push && (wr_ptr_reg == OFIFO_PTR_W'(gi))) begin
                    q_reg <= push_data;
                end
            end

            assign slot_data[gi] = q_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + OFIFO_PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + OFIFO_PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                occ_reg <= occ_reg + OFIFO_OCC_W'(1);
            end else if (!do_push && do_pop) begin
                occ_reg <= occ_reg - OFIFO_OCC_W'(1);
            end
        end
    end

    // While empty, the slot just behind the read pointer is the word that
    // was popped last, so rd_data holds still instead of showing stale slots.
    assign last_ptr = rd_ptr_reg - OFIFO_PTR_W'(1);
    assign head     = (occ_reg == '0) ? slot_data[last_ptr] : slot_data[rd_ptr_reg];
    assign valid    = (occ_reg != '0);
    assign occ      = occ_reg;

endmodule

// File: rtl/rbuf_dp_ctrl.sv
// -----------------------------------------------------------------------------
// rbuf_dp_ctrl
//   Ring-buffer FIFO controller for an external dual-port memory with output
//   register (write port A, read port B, 2-cycle read latency, read-first on
//   address collisions). A prefetch pipe plus a 4-entry output FIFO hides the
//   read latency. The result is a valid/ready stream at 1 word/cycle.
//   Parameters: DEPTH (= 2**ADDR_W), ADDR_W, DATA_W, AFULL_TH.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     flush        : synchronous clear of all contents; wins over all events
//     bus (slave)  : wr_en/wr_data push, full/almost_full/overflow/count flags,
//                    rd_valid/rd_ready/rd_data stream, mem_* memory ports
//   Build option RBUF_DP_CTRL_STAT_EN adds:
//     hwm          : high-water mark of count, cleared by reset/flush
//     ovf_sticky   : set by any dropped push, cleared by reset/flush
// -----------------------------------------------------------------------------
module rbuf_dp_ctrl
    import rbuf_pkg::*;
#(
    parameter int DEPTH    = 2048,
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 8,
    parameter int AFULL_TH = 2040
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
`ifdef RBUF_DP_CTRL_STAT_EN
    output logic [ADDR_W:0] hwm,
    output logic            ovf_sticky,
`endif
    rbuf_dp_ctrl_if.slave   bus
);

    localparam int CW = cnt_w(ADDR_W);

    logic [ADDR_W-1:0]      wptr_reg;
    logic [ADDR_W-1:0]      rptr_reg;
    logic [CW-1:0]          count_reg;
    logic [CW-1:0]          count_next;
    logic [CW-1:0]          mem_avail_reg;
    logic                   full_reg;
    logic                   afull_reg;
    logic                   overflow_reg;
    logic [MEM_RD_LAT-1:0]  tag_reg;
    logic [MEM_RD_LAT-1:0]  tag_next;
    logic [OFIFO_OCC_W-1:0] inflight;
    logic [OFIFO_OCC_W-1:0] ofifo_occ;
    logic                   push_ok;
    logic                   drop;
    logic                   issue;
    logic                   pop;
    logic                   capture;
    logic                   ofifo_valid;
    logic [DATA_W-1:0]      ofifo_head;

    // Push side: full is the registered flag, so a pop in the same cycle does
    // not rescue a push that arrives while full.
    assign push_ok = bus.wr_en & ~full_reg & ~flush;
    assign drop    = bus.wr_en & full_reg & ~flush;

    assign bus.mem_wea   = bus.wr_en & ~full_reg;
    assign bus.mem_addra = wptr_reg;
    assign bus.mem_dia   = bus.mem_wea ? bus.wr_data : '0;

    // The fetch scheduler reserves an output FIFO slot for every read in
    // flight, so a returning word always finds room. mem_avail only counts a
    // write from the cycle after it lands, so a fetch never hits the address
    // being written in the same cycle.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_RD_LAT; i++) begin
            inflight = inflight + OFIFO_OCC_W'(tag_reg[i]);
        end
    end

    assign issue = ~flush & (mem_avail_reg != '0) &
                   ((ofifo_occ + inflight) < OFIFO_OCC_W'(OFIFO_DEPTH));

    assign bus.mem_addrb = rptr_reg;

    // A tag leaving the last stage marks the cycle where mem_resb holds that
    // read. Flush clears the tags, so data still in the memory is dropped.
    assign tag_next = {tag_reg[MEM_RD_LAT-2:0], issue};
    assign capture  = tag_reg[MEM_RD_LAT-1];

    assign pop = ofifo_valid & bus.rd_ready;

    always_comb begin
        count_next = count_reg;
        if (flush) begin
            count_next = '0;
        end else if (push_ok && !pop) begin
            count_next = count_reg + CW'(1);
        end else if (!push_ok && pop) begin
            count_next = count_reg - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            mem_avail_reg <= '0;
            tag_reg       <= '0;
            count_reg     <= '0;
            full_reg      <= 1'b0;
            afull_reg     <= 1'b0;
            overflow_reg  <= 1'b0;
        end else if (flush) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            mem_avail_reg <= '0;
            tag_reg       <= '0;
            count_reg     <= '0;
            full_reg      <= 1'b0;
            afull_reg     <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr_reg <= wptr_reg + ADDR_W'(1);
            end
            if (issue) begin
                rptr_reg <= rptr_reg + ADDR_W'(1);
            end
            if (push_ok && !issue) begin
                mem_avail_reg <= mem_avail_reg + CW'(1);
            end else if (!push_ok && issue) begin
                mem_avail_reg <= mem_avail_reg - CW'(1);
            end
            tag_reg      <= tag_next;
            count_reg    <= count_next;
            full_reg     <= (count_next == CW'(DEPTH));
            afull_reg    <= (count_next >= CW'(AFULL_TH));
            overflow_reg <= drop;
        end
    end

    rbuf_ofifo #(
        .DATA_W (DATA_W)
    ) u_ofifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (capture),
        .push_data (bus.mem_resb),
        .pop       (bus.rd_ready),
        .valid     (ofifo_valid),
        .head      (ofifo_head),
        .occ       (ofifo_occ)
    );

    assign bus.rd_valid    = ofifo_valid;
    assign bus.rd_data     = ofifo_head;
    assign bus.count       = count_reg;
    assign bus.full        = full_reg;
    assign bus.almost_full = afull_reg;
    assign bus.overflow    = overflow_reg;

`ifdef RBUF_DP_CTRL_STAT_EN
    logic [CW-1:0] hwm_reg;
    logic          ovf_sticky_reg;

    // Tracks count_next so the mark moves in the same cycle as count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hwm_reg        <= '0;
            ovf_sticky_reg <= 1'b0;
        end else if (flush) begin
            hwm_reg        <= '0;
            ovf_sticky_reg <= 1'b0;
        end else begin
            if (count_next > hwm_reg) begin
                hwm_reg <= count_next;
            end
            if (drop) begin
                ovf_sticky_reg <= 1'b1;
            end
        end
    end

    assign hwm        = hwm_reg;
    assign ovf_sticky = ovf_sticky_reg;
`endif

endmodule
